// File: rtl/multiplicador_4b.sv
// multiplicador_4b: button-driven 4x4 shift-and-add multiplier with nibble display
module multiplicador_4b #(
  parameter bit ACTIVE_LOW_LEDS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       ok,
  output logic [3:0] leds,
  output logic       busy
);
  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    CALC    = 3'd2,
    SHOW_LO = 3'd3,
    SHOW_HI = 3'd4
  } state_t;
  state_t     state, state_d;
  logic [3:0] a, a_d, b, b_d, leds_r, leds_d, delta;
  logic [7:0] p, p_d;
  logic [1:0] step, step_d;
  logic       up_q, down_q, ok_q, busy_d;
  logic       up_p, down_p, ok_p;
  assign up_p   = up & ~up_q;
  assign down_p = down & ~down_q;
  assign ok_p   = ok & ~ok_q;
  assign delta  = {{3{down_p & ~up_p}}, up_p ^ down_p};
  assign leds   = leds_r ^ {4{ACTIVE_LOW_LEDS}};
  // next-state, operand edits, accumulation and display selection
  always_comb begin
    state_d = state;
    a_d     = a;
    b_d     = b;
    p_d     = p;
    step_d  = step;
    case (state)
      LOAD_A: begin
        a_d     = ok_p ? a : a + delta;
        b_d     = ok_p ? 4'd0 : b;
        state_d = ok_p ? LOAD_B : LOAD_A;
      end
      LOAD_B: begin
        b_d     = ok_p ? b : b + delta;
        p_d     = ok_p ? 8'd0 : p;
        step_d  = 2'd0;
        state_d = ok_p ? CALC : LOAD_B;
      end
      CALC: begin
        p_d     = b[step] ? p + ({4'd0, a} << step) : p;
        step_d  = step + 2'd1;
        state_d = (step == 2'd3) ? SHOW_LO : CALC;
      end
      SHOW_LO: state_d = ok_p ? SHOW_HI : SHOW_LO;
      SHOW_HI: begin
        a_d     = ok_p ? 4'd0 : a;
        state_d = ok_p ? LOAD_A : SHOW_HI;
      end
      default: state_d = LOAD_A;
    endcase
    leds_d = (state_d == LOAD_A)  ? a_d :
             (state_d == LOAD_B)  ? b_d :
             (state_d == SHOW_LO) ? p_d[3:0] :
             (state_d == SHOW_HI) ? p_d[7:4] : 4'd0;
    busy_d = (state_d == CALC);
  end
  // state, datapath, registered outputs and button history
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= LOAD_A;
      a      <= 4'd0;
      b      <= 4'd0;
      p      <= 8'd0;
      step   <= 2'd0;
      leds_r <= 4'd0;
      busy   <= 1'b0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      state  <= state_d;
      a      <= a_d;
      b      <= b_d;
      p      <= p_d;
      step   <= step_d;
      leds_r <= leds_d;
      busy   <= busy_d;
      up_q   <= up;
      down_q <= down;
      ok_q   <= ok;
    end
  end
endmodule

// File: tb/tb_multiplicador_4b.sv
// tb_multiplicador_4b: directed scenario checks of the button multiplier
module tb_multiplicador_4b;
  logic       clk = 1'b0, rst = 1'b0, up = 1'b0, down = 1'b0, ok = 1'b0;
  logic [3:0] leds, leds_n;
  logic       busy, busy_n;
  int         tests = 0, fails = 0;
  localparam int UP = 0, DN = 1, OK = 2;

  multiplicador_4b dut (.clk(clk), .rst(rst), .up(up), .down(down), .ok(ok), .leds(leds), .busy(busy));
  multiplicador_4b #(.ACTIVE_LOW_LEDS(1'b1)) dut_n (.clk(clk), .rst(rst), .up(up), .down(down), .ok(ok), .leds(leds_n), .busy(busy_n));

  always #5 clk = ~clk;

  task automatic set_btn(input int w, input logic v);
    if (w == UP) up = v;
    else if (w == DN) down = v;
    else ok = v;
  endtask

  task automatic press(input int w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_btn(w, 1'b1);
      @(negedge clk);
      set_btn(w, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_calc(input bit noise, output int cyc, output logic [3:0] lo, output logic [3:0] hi);
    press(OK, 1);
    cyc = 0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) begin
      cyc++;
      if (noise) begin
        up   = (cyc % 2 == 1);
        down = (cyc % 2 == 0);
        ok   = (cyc % 2 == 1);
      end
      @(negedge clk);
    end
    up = 1'b0; down = 1'b0; ok = 1'b0;
    lo = leds;
    press(OK, 1);
    hi = leds;
    press(OK, 1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (leds !== 4'h0) begin fails++; $display("FAIL reset_leds got %h want 0", leds); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (leds_n !== 4'hF) begin fails++; $display("FAIL reset_leds_active_low got %h want f", leds_n); end
    up = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    tests++; if (leds !== 4'h1) begin fails++; $display("FAIL held_across_reset got %h want 1", leds); end
    repeat (3) @(negedge clk);
    tests++; if (leds !== 4'h1) begin fails++; $display("FAIL held_single_press got %h want 1", leds); end
    up = 1'b0;
  endtask

  task automatic test_basic();
    int c; logic [3:0] lo, hi;
    do_reset();
    press(UP, 5);
    tests++; if (leds !== 4'h5) begin fails++; $display("FAIL basic_a got %h want 5", leds); end
    press(OK, 1);
    tests++; if (leds !== 4'h0) begin fails++; $display("FAIL basic_b_cleared got %h want 0", leds); end
    press(UP, 3);
    tests++; if (leds !== 4'h3) begin fails++; $display("FAIL basic_b got %h want 3", leds); end
    press(OK, 1);
    c = 0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) begin c++; @(negedge clk); end
    tests++; if (c !== 4) begin fails++; $display("FAIL basic_busy_cycles got %0d want 4", c); end
    tests++; if (leds !== 4'hF) begin fails++; $display("FAIL basic_lo got %h want f", leds); end
    tests++; if (leds_n !== 4'h0) begin fails++; $display("FAIL basic_lo_active_low got %h want 0", leds_n); end
    press(OK, 1);
    tests++; if (leds !== 4'h0) begin fails++; $display("FAIL basic_hi got %h want 0", leds); end
    press(OK, 1);
    tests++; if (leds !== 4'h0 || busy !== 1'b0) begin fails++; $display("FAIL basic_back_to_load_a got leds=%h busy=%b want 0/0", leds, busy); end
    lo = 4'h0; hi = 4'h0;
    if (lo !== hi) $display("note: unreachable");
  endtask

  task automatic test_max();
    int c; logic [3:0] lo, hi;
    do_reset();
    press(DN, 1);
    tests++; if (leds !== 4'hF) begin fails++; $display("FAIL max_a_underflow got %h want f", leds); end
    press(OK, 1);
    press(DN, 1);
    tests++; if (leds !== 4'hF) begin fails++; $display("FAIL max_b_underflow got %h want f", leds); end
    run_calc(1'b0, c, lo, hi);
    tests++; if (lo !== 4'h1) begin fails++; $display("FAIL max_lo got %h want 1", lo); end
    tests++; if (hi !== 4'hE) begin fails++; $display("FAIL max_hi got %h want e", hi); end
  endtask

  task automatic test_zero_and_wrap();
    int c; logic [3:0] lo, hi;
    do_reset();
    press(UP, 7);
    press(OK, 1);
    run_calc(1'b0, c, lo, hi);
    tests++; if (lo !== 4'h0 || hi !== 4'h0) begin fails++; $display("FAIL zero_b_product got lo=%h hi=%h want 0/0", lo, hi); end
    tests++; if (leds !== 4'h0) begin fails++; $display("FAIL zero_a_cleared got %h want 0", leds); end
    press(UP, 15);
    tests++; if (leds !== 4'hF) begin fails++; $display("FAIL wrap_15 got %h want f", leds); end
    press(UP, 1);
    tests++; if (leds !== 4'h0) begin fails++; $display("FAIL wrap_16 got %h want 0", leds); end
  endtask

  task automatic test_held_ok_and_both();
    int c; logic [3:0] lo, hi;
    do_reset();
    press(UP, 2);
    @(negedge clk);
    ok = 1'b1;
    repeat (10) @(negedge clk);
    ok = 1'b0;
    tests++; if (leds !== 4'h0 || busy !== 1'b0) begin fails++; $display("FAIL held_ok_single got leds=%h busy=%b want 0/0", leds, busy); end
    press(UP, 1);
    @(negedge clk);
    up = 1'b1; down = 1'b1;
    @(negedge clk);
    up = 1'b0; down = 1'b0;
    @(negedge clk);
    tests++; if (leds !== 4'h1) begin fails++; $display("FAIL up_down_same_cycle got %h want 1", leds); end
    run_calc(1'b0, c, lo, hi);
    tests++; if (lo !== 4'h2 || hi !== 4'h0) begin fails++; $display("FAIL held_ok_product got lo=%h hi=%h want 2/0", lo, hi); end
  endtask

  task automatic test_back_to_back();
    int c; logic [3:0] lo, hi;
    do_reset();
    press(UP, 3);
    @(negedge clk);
    ok = 1'b1; up = 1'b1;
    @(negedge clk);
    ok = 1'b0; up = 1'b0;
    tests++; if (leds !== 4'h0) begin fails++; $display("FAIL ok_with_up_b got %h want 0", leds); end
    press(UP, 1);
    run_calc(1'b0, c, lo, hi);
    tests++; if (lo !== 4'h3 || hi !== 4'h0) begin fails++; $display("FAIL ok_with_up_a_kept got lo=%h hi=%h want 3/0", lo, hi); end
    press(UP, 4);
    press(OK, 1);
    press(UP, 4);
    run_calc(1'b0, c, lo, hi);
    tests++; if (lo !== 4'h0 || hi !== 4'h1) begin fails++; $display("FAIL back_to_back got lo=%h hi=%h want 0/1", lo, hi); end
  endtask

  task automatic test_reset_mid_calc();
    int c; logic [3:0] lo, hi;
    do_reset();
    press(UP, 3);
    press(OK, 1);
    press(UP, 3);
    press(OK, 1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_calc_busy got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tests++; if (busy !== 1'b0 || leds !== 4'h0) begin fails++; $display("FAIL mid_calc_reset got busy=%b leds=%h want 0/0", busy, leds); end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || leds !== 4'h0) begin fails++; $display("FAIL mid_calc_stays_load_a got busy=%b leds=%h want 0/0", busy, leds); end
    press(OK, 1);
    tests++; if (leds !== 4'h0 || busy !== 1'b0) begin fails++; $display("FAIL mid_calc_b_zero got leds=%h busy=%b want 0/0", leds, busy); end
    press(UP, 5);
    run_calc(1'b0, c, lo, hi);
    tests++; if (lo !== 4'h0 || hi !== 4'h0) begin fails++; $display("FAIL mid_calc_a_zero got lo=%h hi=%h want 0/0", lo, hi); end
  endtask

  task automatic test_calc_noise();
    int c; logic [3:0] lo, hi;
    do_reset();
    press(UP, 9);
    press(OK, 1);
    press(UP, 6);
    run_calc(1'b1, c, lo, hi);
    tests++; if (c !== 4) begin fails++; $display("FAIL noise_busy_cycles got %0d want 4", c); end
    tests++; if (lo !== 4'h6) begin fails++; $display("FAIL noise_lo got %h want 6", lo); end
    tests++; if (hi !== 4'h3) begin fails++; $display("FAIL noise_hi got %h want 3", hi); end
    tests++; if (leds !== 4'h0 || busy !== 1'b0) begin fails++; $display("FAIL noise_load_a got leds=%h busy=%b want 0/0", leds, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_and_wrap();
    test_held_ok_and_both();
    test_back_to_back();
    test_reset_mid_calc();
    test_calc_noise();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multiplicador_4b.md
MULTIPLICADOR_4B -- requirements
Module: multiplicador_4b

Interface
REQ-001 Parameter: ACTIVE_LOW_LEDS, default 0, 1 = leds output bitwise inverted at the pin.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 up  input  1  increment button, level, synchronous to clk.
REQ-005 down  input  1  decrement button, level, synchronous to clk.
REQ-006 ok  input  1  confirm/advance button, level, synchronous to clk.
REQ-007 leds  output  4  display nibble (operand, or product nibble), registered.
REQ-008 busy  output  1  high while multiplication in progress, registered.

Function
REQ-009 Each button SHALL have a previous-value register; press = input 1 while previous 0; one press per 0->1 transition regardless of hold length.
REQ-010 States SHALL be LOAD_A, LOAD_B, CALC, SHOW_LO, SHOW_HI.
REQ-011 LOAD_A: up press -> A+1, down press -> A-1, 4-bit modulo (15+1=0, 0-1=15); leds = A.
REQ-012 up and down pressed in same cycle SHALL leave operand unchanged.
REQ-013 LOAD_A + ok press -> LOAD_B next cycle, B cleared to 0; up/down in the same cycle as ok SHALL be ignored.
REQ-014 LOAD_B: same edit rules on B; leds = B; ok press -> CALC next cycle, accumulator P cleared, step counter = 0.
REQ-015 CALC: exactly 4 cycles, step i=0..3: if B[i]=1 then P = P + (A << i), 8-bit unsigned, no overflow possible.
REQ-016 CALC: busy = 1, leds = 0, all button presses ignored (edge registers still update).
REQ-017 After 4th CALC cycle -> SHOW_LO; busy = 0 in SHOW_LO; total latency ok-press to first valid product on leds = 5 clk edges.
REQ-018 SHOW_LO: leds = P[3:0]; ok press -> SHOW_HI.
REQ-019 SHOW_HI: leds = P[7:4]; ok press -> LOAD_A with A cleared to 0, P retained until next CALC.
REQ-020 up/down SHALL be ignored in SHOW_LO and SHOW_HI.
REQ-021 ACTIVE_LOW_LEDS=1: leds = bitwise NOT of value defined above, including reset value.
REQ-022 No state other than those in REQ-010 reachable; any illegal encoding -> LOAD_A next cycle.

Reset
REQ-023 rst=0 at a rising edge SHALL set state LOAD_A, A=0, B=0, P=0, step=0, busy=0, leds=0 (0xF if ACTIVE_LOW_LEDS=1), button previous registers=0.
REQ-024 Reset SHALL take priority over every event, including mid-CALC; aborted product discarded.
REQ-025 A button held high across reset release SHALL count as one press on the first cycle after release.

Verification
REQ-026 Reset, 5 up presses, ok, 3 up presses, ok -> busy high 4 cycles, then leds=0xF; ok -> leds=0x0; ok -> LOAD_A, leds=0x0.
REQ-027 A=15 (one down press from 0), B=15 -> SHOW_LO leds=0x1, SHOW_HI leds=0xE (225).
REQ-028 A=7, B=0 -> SHOW_LO and SHOW_HI both 0x0; 16 up presses on A -> A returns to 0.
REQ-029 ok held high 10 cycles in LOAD_A -> single transition to LOAD_B only; up and down rising same cycle -> operand unchanged.
REQ-030 rst=0 during 2nd CALC cycle -> next cycle state LOAD_A, busy=0, leds=0, A=B=P=0.
REQ-031 Presses of up/down/ok during CALC -> no effect on result or state; product of A=9, B=6 reads 0x6 then 0x3.
